// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Purpose : shared constants for the UART transmitter and the receiver-side
//           checkers: FSM state encoding, line levels, parity-type encodings
//           and a small parity helper.
// Ports   : none (package).
// Config  : UART_TX_STP2_EN adds the STOP2 state (second stop bit).
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
`ifdef UART_TX_STP2_EN
    ,
    STOP2  = 3'd5
`endif
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  // data_xor is the XOR-reduction of the word; odd parity is its complement.
  function automatic logic parity_bit(input logic data_xor, input logic par_typ);
    logic result;
    result = data_xor;
    case (par_typ)
      EVEN:    result = data_xor;
      ODD:     result = ~data_xor;
      default: result = data_xor;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// ---------------------------------------------------------------------------
// uart_tx_if
// Purpose : groups the transmitter's request side and serial outputs.
// Signals : p_data     - parallel word to send
//           data_valid - request strobe, honoured only while idle
//           par_en     - insert a parity bit after the data bits
//           par_typ    - 0 even / 1 odd parity
//           tx_out     - serial line, idles high
//           busy       - high for every cycle of a frame on tx_out
// Modports: master = system control side, slave = transmitter.
// ---------------------------------------------------------------------------
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_typ,
    input  tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ,
    output tx_out, busy
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
// Purpose : shift register and bit counter for the data portion of a frame.
// Ports   : clk      - TX bit clock
//           rst      - synchronous active-low reset
//           load     - capture data_in and clear the counter
//           shift    - advance to the next data bit
//           data_in  - word to serialize
//           bit_out  - data bit currently selected (LSB first)
//           last_bit - bit_out is the final data bit of the word
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  bit_out,
  output logic                  last_bit
);

  // A one-bit word still needs a one-bit counter.
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      cnt;

  // The counter may run past LAST_IDX on the final shift; the next load clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= data_in;
      cnt   <= '0;
    end else if (shift) begin
      shreg <= shreg >> 1;
      cnt   <= cnt + 1'b1;
    end
  end

  assign bit_out  = shreg[0];
  assign last_bit = (cnt == LAST_IDX);

endmodule

// File: rtl/uart_tx_top.sv
// ---------------------------------------------------------------------------
// uart_tx_top
// Purpose : UART transmitter, one clk cycle per bit. Frame is start bit,
//           DATA_WIDTH data bits LSB first, optional parity, stop bit(s).
// Ports   : clk - TX bit clock
//           rst - synchronous active-low reset
//           bus - uart_tx_if slave modport (p_data, data_valid, par_en,
//                 par_typ in; tx_out, busy out)
// Config  : define UART_TX_STP2_EN for two stop bits (STOP2 state).
// tx_out/busy are registered from the current state, so the line follows the
// FSM by one cycle: tx_out falls on the edge after the accepting edge.
// ---------------------------------------------------------------------------
module uart_tx_top
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  tx_state_t state, next_state;

  logic par_en_q;
  logic par_bit_q;
  logic load;
  logic shift;
  logic bit_out;
  logic last_bit;
  logic tx_next;
  logic busy_next;
  logic tx_q;
  logic busy_q;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift   (shift),
    .data_in (bus.p_data),
    .bit_out (bit_out),
    .last_bit(last_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    shift      = 1'b0;
    tx_next    = IDLE_LVL;
    busy_next  = 1'b1;
    case (state)
      IDLE: begin
        busy_next = 1'b0;
        if (bus.data_valid) begin
          load       = 1'b1;
          next_state = START;
        end
      end
      START: begin
        tx_next    = START_BIT;
        next_state = DATA;
      end
      DATA: begin
        tx_next = bit_out;
        shift   = 1'b1;
        if (last_bit) next_state = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        tx_next    = par_bit_q;
        next_state = STOP;
      end
      STOP: begin
        tx_next = STOP_BIT;
`ifdef UART_TX_STP2_EN
        next_state = STOP2;
`else
        next_state = IDLE;
`endif
      end
`ifdef UART_TX_STP2_EN
      STOP2: begin
        tx_next    = STOP_BIT;
        next_state = IDLE;
      end
`endif
      default: begin
        busy_next  = 1'b0;
        next_state = IDLE;
      end
    endcase
  end

  // Frame options are frozen at acceptance so mid-frame input changes are harmless.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_q      <= IDLE_LVL;
      busy_q    <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      tx_q   <= tx_next;
      busy_q <= busy_next;
      if (load) begin
        par_en_q  <= bus.par_en;
        par_bit_q <= parity_bit(^bus.p_data, bus.par_typ);
      end
    end
  end

  assign bus.tx_out = tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_top.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_top
// Purpose : self-checking bench for uart_tx_top with an 8-bit word.
//           Expected frames come from a behavioural frame model.
// Config  : honours UART_TX_STP2_EN (two stop cycles).
// ---------------------------------------------------------------------------
module tb_uart_tx_top;

`ifdef UART_TX_STP2_EN
  localparam int STOP_CYC = 2;
`else
  localparam int STOP_CYC = 1;
`endif

  logic clk;
  logic rst;
  int   check_cnt;
  int   pass_cnt;

  uart_tx_if #(.DATA_WIDTH(8)) bus_if ();

  uart_tx_top #(.DATA_WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame as seen on the line: bit i is cycle i after the START cycle begins.
  // Cycles beyond the frame are idle (line high, busy low).
  function automatic void model_frame(input logic [7:0] d, input logic pe,
                                      input logic pt, output logic [15:0] tx,
                                      output logic [15:0] bz, output int len);
    int n;
    n  = 0;
    tx = '1;
    bz = '0;
    tx[n] = 1'b0; bz[n] = 1'b1; n++;
    for (int i = 0; i < 8; i++) begin
      tx[n] = d[i]; bz[n] = 1'b1; n++;
    end
    if (pe) begin
      tx[n] = ((($countones(d) % 2) != 0) ? 1'b1 : 1'b0) ^ pt;
      bz[n] = 1'b1; n++;
    end
    for (int s = 0; s < STOP_CYC; s++) begin
      tx[n] = 1'b1; bz[n] = 1'b1; n++;
    end
    len = n;
  endfunction

  // Sends one frame and records len+2 cycles of tx_out/busy (frame plus two idle
  // cycles). inject_at >= 0 raises data_valid with 0x3C during that frame cycle.
  task automatic drive_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input int len, input int inject_at,
                             output logic [15:0] tx_v, output logic [15:0] bz_v,
                             output logic pre_tx, output logic pre_bz);
    tx_v = '1;
    bz_v = '0;
    @(negedge clk);
    bus_if.p_data     = d;
    bus_if.par_en     = pe;
    bus_if.par_typ    = pt;
    bus_if.data_valid = 1'b1;
    @(negedge clk);
    pre_tx = bus_if.tx_out;
    pre_bz = bus_if.busy;
    bus_if.data_valid = 1'b0;
    bus_if.p_data     = 8'($urandom);
    bus_if.par_en     = 1'($urandom);
    bus_if.par_typ    = 1'($urandom);
    for (int k = 0; k < len + 2; k++) begin
      @(negedge clk);
      tx_v[k] = bus_if.tx_out;
      bz_v[k] = bus_if.busy;
      if (k == inject_at) begin
        bus_if.data_valid = 1'b1;
        bus_if.p_data     = 8'h3C;
      end else begin
        bus_if.data_valid = 1'b0;
      end
    end
    bus_if.data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus_if.data_valid = 1'b1;
    bus_if.p_data     = 8'h81;
    repeat (3) @(negedge clk);
    check_cnt++;
    if (bus_if.tx_out !== 1'b1) $display("[TB] FAIL reset_tx: got %b expected 1", bus_if.tx_out);
    else pass_cnt++;
    check_cnt++;
    if (bus_if.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus_if.busy);
    else pass_cnt++;
    bus_if.data_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_cnt++;
    if ({bus_if.tx_out, bus_if.busy} !== 2'b10)
      $display("[TB] FAIL reset_release_idle: got tx/busy %b expected 10", {bus_if.tx_out, bus_if.busy});
    else pass_cnt++;
  endtask

  task automatic test_even_parity();
    logic [15:0] etx, ebz, otx, obz;
    logic        ptx, pbz;
    int          len;
    model_frame(8'hA5, 1'b1, 1'b0, etx, ebz, len);
    drive_frame(8'hA5, 1'b1, 1'b0, len, -1, otx, obz, ptx, pbz);
    check_cnt++;
    if ({ptx, pbz} !== 2'b10)
      $display("[TB] FAIL even_latency: got tx/busy %b at accept cycle expected 10", {ptx, pbz});
    else pass_cnt++;
    check_cnt++;
    if (otx[10:0] !== 11'b10101001010)
      $display("[TB] FAIL even_a5_literal: got %b expected 10101001010", otx[10:0]);
    else pass_cnt++;
    check_cnt++;
    if (otx !== etx) $display("[TB] FAIL even_tx: got %b expected %b", otx, etx);
    else pass_cnt++;
    check_cnt++;
    if (obz !== ebz) $display("[TB] FAIL even_busy: got %b expected %b", obz, ebz);
    else pass_cnt++;
  endtask

  task automatic test_odd_and_no_parity();
    logic [15:0] etx, ebz, otx, obz;
    logic        ptx, pbz;
    int          len;
    model_frame(8'hA5, 1'b1, 1'b1, etx, ebz, len);
    drive_frame(8'hA5, 1'b1, 1'b1, len, -1, otx, obz, ptx, pbz);
    check_cnt++;
    if (otx[9] !== 1'b1) $display("[TB] FAIL odd_parity_slot: got %b expected 1", otx[9]);
    else pass_cnt++;
    check_cnt++;
    if ({otx, obz} !== {etx, ebz})
      $display("[TB] FAIL odd_frame: got %b/%b expected %b/%b", otx, obz, etx, ebz);
    else pass_cnt++;
    model_frame(8'hA5, 1'b0, 1'b1, etx, ebz, len);
    drive_frame(8'hA5, 1'b0, 1'b1, len, -1, otx, obz, ptx, pbz);
    check_cnt++;
    if (len != 9 + STOP_CYC || {otx, obz} !== {etx, ebz})
      $display("[TB] FAIL nopar_frame: got %b/%b expected %b/%b", otx, obz, etx, ebz);
    else pass_cnt++;
  endtask

  task automatic test_ignore_busy();
    logic [15:0] etx, ebz, otx, obz;
    logic        ptx, pbz;
    int          len;
    model_frame(8'hA5, 1'b1, 1'b0, etx, ebz, len);
    drive_frame(8'hA5, 1'b1, 1'b0, len, 3, otx, obz, ptx, pbz);
    check_cnt++;
    if ({otx, obz} !== {etx, ebz})
      $display("[TB] FAIL ignore_busy: got %b/%b expected %b/%b", otx, obz, etx, ebz);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    check_cnt++;
    if ({bus_if.tx_out, bus_if.busy} !== 2'b10)
      $display("[TB] FAIL ignore_busy_no_queue: got tx/busy %b expected 10", {bus_if.tx_out, bus_if.busy});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] f0tx, f0bz, f1tx, f1bz;
    logic [39:0] etx, ebz, otx, obz;
    int          len0, len1;
    model_frame(8'h00, 1'b1, 1'b0, f0tx, f0bz, len0);
    model_frame(8'hFF, 1'b1, 1'b0, f1tx, f1bz, len1);
    etx = '1; ebz = '0; otx = '1; obz = '0;
    for (int i = 0; i < len0; i++) begin
      etx[i] = f0tx[i]; ebz[i] = f0bz[i];
    end
    for (int i = 0; i < len1; i++) begin
      etx[len0 + 1 + i] = f1tx[i]; ebz[len0 + 1 + i] = f1bz[i];
    end
    @(negedge clk);
    bus_if.p_data     = 8'h00;
    bus_if.par_en     = 1'b1;
    bus_if.par_typ    = 1'b0;
    bus_if.data_valid = 1'b1;
    @(negedge clk);
    bus_if.p_data = 8'hFF;
    for (int k = 0; k < len0 + len1 + 3; k++) begin
      @(negedge clk);
      otx[k] = bus_if.tx_out;
      obz[k] = bus_if.busy;
      if (k == len0) bus_if.data_valid = 1'b0;
    end
    check_cnt++;
    if (otx !== etx) $display("[TB] FAIL b2b_tx: got %b expected %b", otx, etx);
    else pass_cnt++;
    check_cnt++;
    if (obz !== ebz) $display("[TB] FAIL b2b_busy: got %b expected %b", obz, ebz);
    else pass_cnt++;
    check_cnt++;
    if ({otx[9], otx[len0 + 10]} !== 2'b00)
      $display("[TB] FAIL b2b_parity_bits: got %b expected 00", {otx[9], otx[len0 + 10]});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] etx, ebz, otx, obz;
    logic        ptx, pbz;
    int          len;
    @(negedge clk);
    bus_if.p_data     = 8'hA5;
    bus_if.par_en     = 1'b1;
    bus_if.par_typ    = 1'b0;
    bus_if.data_valid = 1'b1;
    @(negedge clk);
    bus_if.data_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_cnt++;
    if ({bus_if.tx_out, bus_if.busy} !== 2'b10)
      $display("[TB] FAIL midframe_reset: got tx/busy %b expected 10", {bus_if.tx_out, bus_if.busy});
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    check_cnt++;
    if ({bus_if.tx_out, bus_if.busy} !== 2'b10)
      $display("[TB] FAIL midframe_after_release: got tx/busy %b expected 10", {bus_if.tx_out, bus_if.busy});
    else pass_cnt++;
    model_frame(8'h55, 1'b1, 1'b0, etx, ebz, len);
    drive_frame(8'h55, 1'b1, 1'b0, len, -1, otx, obz, ptx, pbz);
    check_cnt++;
    if ({otx, obz} !== {etx, ebz})
      $display("[TB] FAIL midframe_new_frame: got %b/%b expected %b/%b", otx, obz, etx, ebz);
    else pass_cnt++;
  endtask

  task automatic test_parity_sweep();
    logic [15:0] etx, ebz, otx, obz;
    logic        ptx, pbz;
    int          len;
    for (int t = 0; t < 2; t++) begin
      for (int v = 0; v < 256; v++) begin
        model_frame(8'(v), 1'b1, 1'(t), etx, ebz, len);
        drive_frame(8'(v), 1'b1, 1'(t), len, -1, otx, obz, ptx, pbz);
        check_cnt++;
        if ({otx, obz} !== {etx, ebz})
          $display("[TB] FAIL sweep_%0d_%0d: got %b/%b expected %b/%b", v, t, otx, obz, etx, ebz);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] etx, ebz, otx, obz;
    logic        ptx, pbz;
    logic [7:0]  d;
    logic        pe, pt;
    int          len;
    for (int n = 0; n < 40; n++) begin
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      model_frame(d, pe, pt, etx, ebz, len);
      drive_frame(d, pe, pt, len, -1, otx, obz, ptx, pbz);
      check_cnt++;
      if ({otx, obz, ptx, pbz} !== {etx, ebz, 2'b10})
        $display("[TB] FAIL random_%0d d=%h pe=%b pt=%b: got %b/%b expected %b/%b",
                 n, d, pe, pt, otx, obz, etx, ebz);
      else pass_cnt++;
    end
  endtask

  initial begin
    check_cnt         = 0;
    pass_cnt          = 0;
    rst               = 1'b0;
    bus_if.data_valid = 1'b0;
    bus_if.p_data     = '0;
    bus_if.par_en     = 1'b0;
    bus_if.par_typ    = 1'b0;
    test_reset();
    test_even_parity();
    test_odd_and_no_parity();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_parity_sweep();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_top.md
Name: uart_tx_top

Overview:
- UART transmitter; the partner of the system's UART receiver.
- Takes a parallel word with a valid strobe from the system control side.
- Serializes it as start bit, data LSB-first, optional parity bit, then stop bit.
- Runs on the UART TX clock: one clk cycle per transmitted bit, so oversampling is the receiver's job.

Parameters:
DATA_WIDTH, 8, width of the parallel data word and number of serialized data bits

Ports:
clk  input  1  UART TX clock; one bit period per cycle
rst  input  1  synchronous, active-low reset, sampled on rising clk
p_data  input  DATA_WIDTH  parallel word to send; sampled only at acceptance
data_valid  input  1  request strobe; accepted only when the block is idle
par_en  input  1  1 = parity bit inserted after the data bits
par_typ  input  1  0 = even parity, 1 = odd parity; ignored when par_en=0
tx_out  output  1  serial line, idles high
busy  output  1  high while a frame is in progress, including the accept cycle's frame

Interface decided: single clock clk; reset rst is synchronous and active-low.

Behaviour:
- Reset (rst=0 at a rising edge): state=IDLE, tx_out=1, busy=0, bit counter=0, data/parity registers=0. Reset wins over every other input, including mid-frame; the frame is aborted and the line returns high on the same edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FSM states are IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_out=1, busy=0.
  - If data_valid=1 at edge N, latch p_data, par_en and par_typ, compute the parity bit, and go to START.
  - Even parity bit = XOR of data; odd parity bit = XNOR of data.
- START: tx_out=0, busy=1 for one cycle, then go to DATA.
- DATA:
  - Emits latched bit[k] for k=0..DATA_WIDTH-1, one per cycle, LSB first.
  - The counter is $clog2(DATA_WIDTH) bits wide and compares against DATA_WIDTH-1 with no wrap dependence.
  - After the last bit, go to PARITY if par_en was latched high, else STOP.
- PARITY: tx_out=latched parity bit, busy=1, one cycle, then go to STOP.
- STOP: tx_out=1, busy=1, one cycle, then go to IDLE.
- Frame length seen at tx_out is 1+DATA_WIDTH+par_en+1 cycles (10 or 11 for the default width). busy is high for exactly those cycles.
- data_valid outside IDLE is ignored: it is neither queued nor corrupting. Changes to p_data, par_en or par_typ mid-frame have no effect.
- Back-to-back: with data_valid held high, the next frame is accepted in the IDLE cycle after STOP. This gives exactly one idle-high cycle between frames.
- Latency: tx_out falls on the first edge after the accepting edge, i.e. one cycle after data_valid is sampled.

Optional Feature:
- Macro: UART_TX_STP2_EN.
- Defined: a STOP2 state follows STOP, giving two high stop cycles. busy covers both; the frame is 1+DATA_WIDTH+par_en+2 cycles.
- Undefined: a single stop bit, exactly as above, and no STOP2 state exists in the RTL.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding constants: IDLE, START, DATA, PARITY, STOP, STOP2.
  - Line levels: START_BIT=0, STOP_BIT=1, IDLE_LVL=1.
  - Parity-type encodings: EVEN=0, ODD=1.
- These same constants are reused by the receiver's checkers.
- One natural sub-module, uart_tx_serializer: holds the shift register and bit counter, loads on accept, and flags the last bit.
- The FSM, parity computation and output mux stay in the top.

Test Plan:
- Even parity: p_data=0xA5, par_en=1, par_typ=0, data_valid pulse → tx_out = 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles. busy is high for those 11 cycles, then tx_out=1 and busy=0.
- Odd parity and no parity: same word with par_typ=1 → parity cycle=1. With par_en=0 → 10-cycle frame with no parity slot, and stop follows bit 7.
- Ignore while busy: data_valid=1 with p_data=0x3C during cycle 4 of an 0xA5 frame → 0xA5 frame is unchanged, and no 0x3C frame follows.
- Back-to-back: data_valid held high, p_data=0x00 then 0xFF, par_en=1 par_typ=0 → two 11-cycle frames separated by exactly one tx_out=1 cycle. Parity bits are 0 and 0.
- Reset mid-frame: rst=0 during data bit 3 → at that edge tx_out=1 and busy=0. After release, a new frame for 0x55 is sent correctly.
- Parity sweep: all 256 data values × par_typ {0,1} → the parity slot equals XOR/XNOR of the data, checked by a reference model; bench loopback into the receiver shows par_err=0 and data_valid=1.
